// File: rtl/port_out_fifo.sv
// Output-port word FIFO: class-checked push, first-word fall-through pop,
// one-cycle error pulses and a saturating count of rejected words.
module port_out_fifo #(
  parameter int DATA_SIZE  = 10,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_SIZE   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_SIZE-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [DATA_SIZE-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 almost_full,
  output logic                 empty,
  output logic                 error_class,
  output logic                 error_overflow,
  output logic [CNT_SIZE-1:0]  drop_count
);
  localparam int                PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]    DEPTH_C  = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]    CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_SIZE-1:0] DROP_ONE = CNT_SIZE'(1);

  logic [DATA_SIZE-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [PTR_W:0]       count;
  logic                 live;
  logic [1:0]           cls;
  logic                 full, legal, push, pop, class_hit, over_hit;

  assign cls         = in_data[DATA_SIZE-1 -: 2];
  assign legal       = (cls == 2'b00) || (cls == 2'b11);
  assign full        = (count == DEPTH_C);
  // live holds in_ready low until the first edge after reset release
  assign in_ready    = live && !full;
  assign out_valid   = (count != '0);
  assign empty       = !out_valid;
  assign almost_full = (count >= (DEPTH_C - CNT_ONE));
  assign out_data    = mem[rd_ptr];

  assign push      = in_valid && in_ready && legal;
  assign pop       = out_valid && out_ready;
  assign class_hit = in_valid && in_ready && !legal;
  assign over_hit  = in_valid && full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      live           <= 1'b0;
      error_class    <= 1'b0;
      error_overflow <= 1'b0;
      drop_count     <= '0;
    end else begin
      live           <= 1'b1;
      error_class    <= class_hit;
      error_overflow <= over_hit;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)      count <= count + CNT_ONE;
      else if (pop && !push) count <= count - CNT_ONE;
      if ((class_hit || over_hit) && (drop_count != '1))
        drop_count <= drop_count + DROP_ONE;
    end
  end
endmodule

// File: tb/tb_port_out_fifo.sv
// Bench for port_out_fifo: directed scenarios plus random traffic against a
// queue-based model of the FIFO rules.
module tb_port_out_fifo;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] in_data;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [9:0] out_data;
  logic       almost_full, empty, error_class, error_overflow;
  logic [7:0] drop_count;

  int total = 0;
  int bad   = 0;

  logic [9:0] q[$];
  bit         live;
  bit         m_ec, m_eo;
  int         m_drops;

  port_out_fifo #(.DATA_SIZE(10), .FIFO_DEPTH(DEPTH), .CNT_SIZE(8)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .almost_full(almost_full), .empty(empty),
    .error_class(error_class), .error_overflow(error_overflow),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    q.delete();
    live = 0; m_ec = 0; m_eo = 0; m_drops = 0;
  endtask

  // drive one cycle, advance the model across the edge, settle 1 time unit
  task automatic step(input logic v, input logic [9:0] d, input logic r);
    bit m_full, m_rdy, m_legal, m_pop, m_push;
    in_valid = v; in_data = d; out_ready = r;
    @(posedge clk);
    m_full  = (q.size() == DEPTH);
    m_rdy   = live && !m_full;
    m_legal = (d[9:8] == 2'b00) || (d[9:8] == 2'b11);
    m_pop   = r && (q.size() != 0);
    m_push  = v && m_rdy && m_legal;
    m_eo    = v && m_full;
    m_ec    = v && m_rdy && !m_legal;
    if ((m_eo || m_ec) && m_drops < 255) m_drops++;
    if (m_pop) void'(q.pop_front());
    if (m_push) q.push_back(d);
    live = 1;
    #1;
  endtask

  task automatic test_reset();
    in_valid = 0; in_data = '0; out_ready = 0;
    reset = 1; model_clear();
    repeat (3) @(posedge clk);
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL rst_empty got=%b exp=1", empty); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    total++; if (out_data !== 10'h000) begin bad++; $display("FAIL rst_out_data got=%h exp=000", out_data); end
    total++; if (drop_count !== 8'd0) begin bad++; $display("FAIL rst_drop got=%0d exp=0", drop_count); end
    total++; if ({almost_full, error_class, error_overflow} !== 3'b000) begin bad++; $display("FAIL rst_flags got=%b exp=000", {almost_full, error_class, error_overflow}); end
    #2 reset = 0;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rel_in_ready_early got=%b exp=0", in_ready); end
    step(0, '0, 0);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rel_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_fill_overflow();
    step(1, 10'h0FF, 0);
    total++; if (out_data !== 10'h0FF || out_valid !== 1'b1) begin bad++; $display("FAIL fwft_latency got=%h/%b exp=0ff/1", out_data, out_valid); end
    step(1, 10'h3DD, 0);
    step(1, 10'h0EE, 0);
    total++; if (almost_full !== 1'b1) begin bad++; $display("FAIL fill3_almost_full got=%b exp=1", almost_full); end
    total++; if (out_data !== 10'h0FF) begin bad++; $display("FAIL fill3_out_data got=%h exp=0ff", out_data); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL fill3_in_ready got=%b exp=1", in_ready); end
    step(1, 10'h3CC, 0);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_in_ready got=%b exp=0", in_ready); end
    step(1, 10'h0BB, 0);
    total++; if (error_overflow !== 1'b1 || error_class !== 1'b0) begin bad++; $display("FAIL ovf_pulse got=%b%b exp=10", error_overflow, error_class); end
    total++; if (drop_count !== 8'd1) begin bad++; $display("FAIL ovf_drop got=%0d exp=1", drop_count); end
    step(0, '0, 0);
    total++; if (error_overflow !== 1'b0) begin bad++; $display("FAIL ovf_one_cycle got=%b exp=0", error_overflow); end
    total++; if (out_data !== 10'h0FF) begin bad++; $display("FAIL ovf_hold got=%h exp=0ff", out_data); end
  endtask

  task automatic test_drain();
    logic [9:0] exp_seq [4];
    exp_seq[0] = 10'h0FF; exp_seq[1] = 10'h3DD; exp_seq[2] = 10'h0EE; exp_seq[3] = 10'h3CC;
    for (int i = 0; i < 4; i++) begin
      total++; if (out_data !== exp_seq[i]) begin bad++; $display("FAIL drain_%0d got=%h exp=%h", i, out_data, exp_seq[i]); end
      step(0, '0, 1);
    end
    total++; if (empty !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL drain_empty got=%b/%b exp=1/0", empty, out_valid); end
  endtask

  task automatic test_class_error();
    step(1, 10'h1AA, 0);
    total++; if (error_class !== 1'b1 || empty !== 1'b1) begin bad++; $display("FAIL cls1 got=%b/%b exp=1/1", error_class, empty); end
    step(1, 10'h2BB, 0);
    total++; if (error_class !== 1'b1 || empty !== 1'b1) begin bad++; $display("FAIL cls2 got=%b/%b exp=1/1", error_class, empty); end
    step(0, '0, 0);
    total++; if (error_class !== 1'b0) begin bad++; $display("FAIL cls_end got=%b exp=0", error_class); end
    total++; if (drop_count !== 8'd3) begin bad++; $display("FAIL cls_drop got=%0d exp=3", drop_count); end
  endtask

  task automatic test_back_to_back();
    logic [9:0] words [3];
    words[0] = 10'h0AA; words[1] = 10'h388; words[2] = 10'h377;
    for (int i = 0; i < 3; i++) begin
      step(1, words[i], 1);
      total++; if (out_data !== words[i] || out_valid !== 1'b1 || almost_full !== 1'b0) begin bad++; $display("FAIL b2b_%0d got=%h/%b/%b exp=%h/1/0", i, out_data, out_valid, almost_full, words[i]); end
    end
    step(0, '0, 1);
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL b2b_empty got=%b exp=1", empty); end
  endtask

  task automatic test_reset_mid();
    step(1, 10'h011, 0);
    step(1, 10'h322, 0);
    step(1, 10'h033, 0);
    #2 reset = 1; model_clear();
    #1;
    total++; if (out_valid !== 1'b0 || empty !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_flags got=%b%b%b exp=010", out_valid, empty, in_ready); end
    total++; if (out_data !== 10'h000 || drop_count !== 8'd0 || almost_full !== 1'b0) begin bad++; $display("FAIL mid_rst_data got=%h/%0d/%b exp=000/0/0", out_data, drop_count, almost_full); end
    #3 reset = 0;
    step(0, '0, 0);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_rel_stale got=%b exp=0", out_valid); end
    step(1, 10'h0FF, 0);
    total++; if (out_data !== 10'h0FF || out_valid !== 1'b1) begin bad++; $display("FAIL mid_rel_first got=%h/%b exp=0ff/1", out_data, out_valid); end
  endtask

  task automatic test_random();
    logic [9:0] d;
    for (int n = 0; n < 400; n++) begin
      d = 10'($urandom);
      step(($urandom_range(0, 3) != 0), d, ($urandom_range(0, 2) == 0));
      total++; if (out_valid !== (q.size() != 0)) begin bad++; $display("FAIL rnd_out_valid n=%0d got=%b exp=%b", n, out_valid, q.size() != 0); end
      if (q.size() != 0) begin
        total++; if (out_data !== q[0]) begin bad++; $display("FAIL rnd_out_data n=%0d got=%h exp=%h", n, out_data, q[0]); end
      end
      total++; if (in_ready !== (q.size() < DEPTH)) begin bad++; $display("FAIL rnd_in_ready n=%0d got=%b exp=%b", n, in_ready, q.size() < DEPTH); end
      total++; if (almost_full !== (q.size() >= DEPTH - 1)) begin bad++; $display("FAIL rnd_almost_full n=%0d got=%b", n, almost_full); end
      total++; if (error_class !== m_ec || error_overflow !== m_eo) begin bad++; $display("FAIL rnd_err n=%0d got=%b%b exp=%b%b", n, error_class, error_overflow, m_ec, m_eo); end
      total++; if (drop_count !== 8'(m_drops)) begin bad++; $display("FAIL rnd_drop n=%0d got=%0d exp=%0d", n, drop_count, m_drops); end
    end
  endtask

  task automatic test_saturate();
    for (int n = 0; n < 300; n++) step(1, 10'h155, 1);
    total++; if (m_drops != 255 || drop_count !== 8'd255) begin bad++; $display("FAIL sat_drop got=%0d exp=255", drop_count); end
    step(1, 10'h2AA, 0);
    total++; if (drop_count !== 8'd255 || error_class !== 1'b1) begin bad++; $display("FAIL sat_hold got=%0d/%b exp=255/1", drop_count, error_class); end
  endtask

  initial begin
    test_reset();
    test_fill_overflow();
    test_drain();
    test_class_error();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
